// File: rtl/puzzle_move_engine.sv
// Sliding-tile puzzle engine: load/scan for the blank, then edge-triggered moves.
// Optional single-step undo history is built when PUZZLE_UNDO_EN is defined.
module puzzle_move_engine #(
  parameter int ROWS   = 3,
  parameter int COLS   = 3,
  parameter int CELL_W = 4,
  parameter int CNT_W  = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [ROWS*COLS*CELL_W-1:0]   board_in,
  input  logic                          l,
  input  logic                          r,
  input  logic                          u,
  input  logic                          d,
  input  logic                          undo,
  output logic [ROWS*COLS*CELL_W-1:0]   board_out,
  output logic [$clog2(ROWS*COLS)-1:0]  blank_idx,
  output logic                          ready,
  output logic                          move_pulse,
  output logic                          illegal,
  output logic                          no_blank,
  output logic                          solved,
  output logic [CNT_W-1:0]              move_count
);
  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int BW = N * CELL_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_READY
  } state_t;

  // Opposite direction is the encoding with bit 0 flipped.
  typedef enum logic [1:0] {
    D_L = 2'd0,
    D_R = 2'd1,
    D_U = 2'd2,
    D_D = 2'd3
  } dir_t;

  state_t           r_state, w_state_nxt;
  logic [BW-1:0]    r_board, w_board_nxt;
  logic [IW-1:0]    r_blank, w_blank_nxt;
  logic [IW-1:0]    r_k, w_k_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_pulse, w_pulse_nxt;
  logic             r_ill, w_ill_nxt;
  logic             r_nob, w_nob_nxt;
  logic             r_solved, w_solved_nxt;
  logic             r_l_q, r_r_q, r_u_q, r_d_q;
  logic             w_l_re, w_r_re, w_u_re, w_d_re;
  logic             w_fire, w_is_undo, w_legal, w_hist_ok;
  dir_t             w_dir;
  int               w_row, w_col, w_nb;

`ifdef PUZZLE_UNDO_EN
  logic r_undo_q, w_undo_re;
  logic r_hist_v, w_hist_v_nxt;
  dir_t r_hist_dir, w_hist_dir_nxt;

  assign w_undo_re = undo & ~r_undo_q;
  assign w_hist_ok = !w_is_undo || r_hist_v;
`else
  logic w_unused;

  assign w_unused  = undo;
  assign w_hist_ok = 1'b1;
`endif

  assign w_l_re = l & ~r_l_q;
  assign w_r_re = r & ~r_r_q;
  assign w_u_re = u & ~r_u_q;
  assign w_d_re = d & ~r_d_q;

  function automatic logic is_solved(input logic [BW-1:0] b);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (k == N - 1) begin
        if (b[k*CELL_W +: CELL_W] != '0) ok = 1'b0;
      end else if (b[k*CELL_W +: CELL_W] != CELL_W'(k + 1)) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

  always_comb begin
    w_fire    = 1'b1;
    w_is_undo = 1'b0;
    w_dir     = D_L;
    if (w_l_re) w_dir = D_L;
    else if (w_r_re) w_dir = D_R;
    else if (w_u_re) w_dir = D_U;
    else if (w_d_re) w_dir = D_D;
`ifdef PUZZLE_UNDO_EN
    else if (w_undo_re) begin
      w_is_undo = 1'b1;
      w_dir     = dir_t'(r_hist_dir ^ 2'b01);
    end
`endif
    else w_fire = 1'b0;
  end

  always_comb begin
    w_row = int'(r_blank) / COLS;
    w_col = int'(r_blank) % COLS;
    unique case (w_dir)
      D_L: begin
        w_legal = (w_col != 0);
        w_nb    = int'(r_blank) - 1;
      end
      D_R: begin
        w_legal = (w_col != COLS - 1);
        w_nb    = int'(r_blank) + 1;
      end
      D_U: begin
        w_legal = (w_row != 0);
        w_nb    = int'(r_blank) - COLS;
      end
      default: begin
        w_legal = (w_row != ROWS - 1);
        w_nb    = int'(r_blank) + COLS;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_board_nxt = r_board;
    w_blank_nxt = r_blank;
    w_k_nxt     = r_k;
    w_cnt_nxt   = r_cnt;
    w_nob_nxt   = r_nob;
    w_pulse_nxt = 1'b0;
    w_ill_nxt   = 1'b0;
`ifdef PUZZLE_UNDO_EN
    w_hist_v_nxt   = r_hist_v;
    w_hist_dir_nxt = r_hist_dir;
`endif
    if (load) begin
      w_state_nxt = S_SCAN;
      w_board_nxt = board_in;
      w_k_nxt     = '0;
      w_cnt_nxt   = '0;
      w_nob_nxt   = 1'b0;
`ifdef PUZZLE_UNDO_EN
      w_hist_v_nxt = 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_SCAN: begin
          if (r_board[int'(r_k)*CELL_W +: CELL_W] == '0) begin
            w_blank_nxt = r_k;
            w_state_nxt = S_READY;
          end else if (r_k == IW'(N - 1)) begin
            w_nob_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_k_nxt = r_k + 1'b1;
          end
        end
        S_READY: begin
          if (w_fire) begin
            if (!w_legal || !w_hist_ok) begin
              w_ill_nxt = 1'b1;
            end else begin
              w_board_nxt[int'(r_blank)*CELL_W +: CELL_W] =
                r_board[w_nb*CELL_W +: CELL_W];
              w_board_nxt[w_nb*CELL_W +: CELL_W] = '0;
              w_blank_nxt = IW'(w_nb);
              w_pulse_nxt = 1'b1;
              if (!w_is_undo && r_cnt != '1) w_cnt_nxt = r_cnt + 1'b1;
`ifdef PUZZLE_UNDO_EN
              w_hist_v_nxt   = !w_is_undo;
              w_hist_dir_nxt = w_dir;
`endif
            end
          end
        end
        default: ;
      endcase
    end
    w_solved_nxt = (w_state_nxt == S_READY) && is_solved(w_board_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_board  <= '0;
      r_blank  <= '0;
      r_k      <= '0;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
      r_ill    <= 1'b0;
      r_nob    <= 1'b0;
      r_solved <= 1'b0;
      r_l_q    <= 1'b0;
      r_r_q    <= 1'b0;
      r_u_q    <= 1'b0;
      r_d_q    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_board  <= w_board_nxt;
      r_blank  <= w_blank_nxt;
      r_k      <= w_k_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pulse  <= w_pulse_nxt;
      r_ill    <= w_ill_nxt;
      r_nob    <= w_nob_nxt;
      r_solved <= w_solved_nxt;
      r_l_q    <= l;
      r_r_q    <= r;
      r_u_q    <= u;
      r_d_q    <= d;
    end
  end

`ifdef PUZZLE_UNDO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_undo_q   <= 1'b0;
      r_hist_v   <= 1'b0;
      r_hist_dir <= D_L;
    end else begin
      r_undo_q   <= undo;
      r_hist_v   <= w_hist_v_nxt;
      r_hist_dir <= w_hist_dir_nxt;
    end
  end
`endif

  assign board_out  = r_board;
  assign blank_idx  = r_blank;
  assign ready      = (r_state == S_READY);
  assign move_pulse = r_pulse;
  assign illegal    = r_ill;
  assign no_blank   = r_nob;
  assign solved     = r_solved;
  assign move_count = r_cnt;

endmodule

// File: tb/tb_puzzle_move_engine.sv
// Bench for puzzle_move_engine: directed scenarios plus random moves
// checked against an array-based model of the board.
module tb_puzzle_move_engine;
  localparam int ROWS = 3;
  localparam int COLS = 3;
  localparam int CW   = 4;
  localparam int CNTW = 10;
  localparam int N    = ROWS * COLS;
  localparam int BW   = N * CW;
  localparam int IW   = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  typedef int brd_t[N];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b0;
  logic l = 1'b0, r = 1'b0, u = 1'b0, d = 1'b0, undo = 1'b0;
  logic [BW-1:0] board_in = '0;
  logic [BW-1:0] board_out;
  logic [IW-1:0] blank_idx;
  logic ready, move_pulse, illegal, no_blank, solved;
  logic [CNTW-1:0] move_count;

  int checks = 0;
  int failures = 0;

  brd_t mb;
  int mbl, mcnt, mhd;
  bit mhv;

  puzzle_move_engine #(
    .ROWS(ROWS), .COLS(COLS), .CELL_W(CW), .CNT_W(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .board_in(board_in),
    .l(l), .r(r), .u(u), .d(d), .undo(undo),
    .board_out(board_out), .blank_idx(blank_idx), .ready(ready),
    .move_pulse(move_pulse), .illegal(illegal), .no_blank(no_blank),
    .solved(solved), .move_count(move_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] m);
    l = m[0];
    r = m[1];
    u = m[2];
    d = m[3];
    undo = m[4];
  endtask

  function automatic logic [BW-1:0] pk(input brd_t c);
    logic [BW-1:0] v;
    for (int k = 0; k < N; k++) v[k*CW +: CW] = CW'(c[k]);
    return v;
  endfunction

  function automatic bit msolved();
    for (int k = 0; k < N - 1; k++) if (mb[k] != k + 1) return 1'b0;
    return mb[N-1] == 0;
  endfunction

  function automatic bit mmove(input int dir);
    int row, col, nb;
    bit ok;
    row = mbl / COLS;
    col = mbl % COLS;
    case (dir)
      0: begin ok = col > 0; nb = mbl - 1; end
      1: begin ok = col < COLS - 1; nb = mbl + 1; end
      2: begin ok = row > 0; nb = mbl - COLS; end
      default: begin ok = row < ROWS - 1; nb = mbl + COLS; end
    endcase
    if (ok) begin
      mb[mbl] = mb[nb];
      mb[nb] = 0;
      mbl = nb;
    end
    return ok;
  endfunction

  task automatic model_press(input logic [4:0] m, output bit ep, output bit ei);
    int w;
    w = -1;
    ep = 1'b0;
    ei = 1'b0;
    for (int i = 0; i < 5; i++) if (m[i] && w < 0) w = i;
    if (w == 4) begin
`ifdef PUZZLE_UNDO_EN
      if (mhv) begin
        void'(mmove(mhd ^ 1));
        mhv = 1'b0;
        ep = 1'b1;
      end else begin
        ei = 1'b1;
      end
`endif
    end else if (w >= 0) begin
      if (mmove(w)) begin
        mcnt = (mcnt < CMAX) ? mcnt + 1 : CMAX;
        mhv = 1'b1;
        mhd = w;
        ep = 1'b1;
      end else begin
        ei = 1'b1;
      end
    end
  endtask

  task automatic do_load(input brd_t c, output int lat);
    board_in = pk(c);
    load = 1'b1;
    step();
    load = 1'b0;
    lat = 0;
    for (int i = 1; i <= N + 3; i++) begin
      step();
      if (ready || no_blank) begin
        lat = i;
        break;
      end
    end
    mb = c;
    mbl = -1;
    for (int k = 0; k < N; k++) if (mb[k] == 0 && mbl < 0) mbl = k;
    mcnt = 0;
    mhv = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (board_out !== '0 || blank_idx !== '0 || ready !== 1'b0 ||
        move_pulse !== 1'b0 || illegal !== 1'b0 || no_blank !== 1'b0 ||
        solved !== 1'b0 || move_count !== '0) begin
      failures++;
      $display("FAIL reset_state board=%h blank=%0d rdy=%b pulse=%b ill=%b nob=%b sol=%b cnt=%0d",
               board_out, blank_idx, ready, move_pulse, illegal, no_blank, solved, move_count);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (ready !== 1'b0 || board_out !== '0) begin
      failures++;
      $display("FAIL reset_idle rdy=%b board=%h expected rdy=0 board=0", ready, board_out);
    end
  endtask

  task automatic test_solved_and_left();
    int lat;
    brd_t s = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
    brd_t e = '{1, 2, 3, 4, 5, 6, 7, 0, 8};
    do_load(s, lat);
    checks++;
    if (lat != 9 || blank_idx !== 4'd8 || solved !== 1'b1 ||
        move_count !== '0 || board_out !== pk(s)) begin
      failures++;
      $display("FAIL load_solved lat=%0d/9 blank=%0d/8 sol=%b/1 cnt=%0d/0",
               lat, blank_idx, solved, move_count);
    end
    drive(5'b00001);
    step();
    checks++;
    if (board_out !== pk(e) || blank_idx !== 4'd7 || solved !== 1'b0 ||
        move_count !== 10'd1 || move_pulse !== 1'b1) begin
      failures++;
      $display("FAIL move_left board=%h/%h blank=%0d/7 sol=%b/0 cnt=%0d/1 pulse=%b/1",
               board_out, pk(e), blank_idx, solved, move_count, move_pulse);
    end
    drive(5'b00000);
    step();
    checks++;
    if (move_pulse !== 1'b0) begin
      failures++;
      $display("FAIL pulse_width pulse=%b expected 0", move_pulse);
    end
  endtask

  task automatic test_edges();
    int lat;
    int nill;
    brd_t s = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    do_load(s, lat);
    checks++;
    if (lat != 1 || blank_idx !== '0) begin
      failures++;
      $display("FAIL load_blank0 lat=%0d/1 blank=%0d/0", lat, blank_idx);
    end
    nill = 0;
    drive(5'b00100);
    step();
    nill += int'(illegal);
    drive(5'b00000);
    step();
    nill += int'(illegal);
    drive(5'b00001);
    step();
    nill += int'(illegal);
    drive(5'b00000);
    step();
    nill += int'(illegal);
    checks++;
    if (nill != 2 || board_out !== pk(s) || move_count !== '0 || blank_idx !== '0) begin
      failures++;
      $display("FAIL edge_illegal ill_pulses=%0d/2 board=%h/%h cnt=%0d/0",
               nill, board_out, pk(s), move_count);
    end
  endtask

  task automatic test_priority_hold();
    int lat;
    int np;
    brd_t s = '{1, 2, 3, 4, 0, 5, 6, 7, 8};
    brd_t e = '{1, 2, 3, 0, 4, 5, 6, 7, 8};
    do_load(s, lat);
    checks++;
    if (lat != 5 || blank_idx !== 4'd4) begin
      failures++;
      $display("FAIL load_center lat=%0d/5 blank=%0d/4", lat, blank_idx);
    end
    drive(5'b01001);
    step();
    checks++;
    if (blank_idx !== 4'd3 || board_out !== pk(e) || move_count !== 10'd1) begin
      failures++;
      $display("FAIL priority_ld blank=%0d/3 board=%h/%h cnt=%0d/1",
               blank_idx, board_out, pk(e), move_count);
    end
    drive(5'b00001);
    np = 0;
    for (int i = 0; i < 19; i++) begin
      step();
      np += int'(move_pulse) + int'(illegal);
    end
    drive(5'b00000);
    step();
    checks++;
    if (np != 0 || move_count !== 10'd1 || blank_idx !== 4'd3) begin
      failures++;
      $display("FAIL held_button extra_pulses=%0d/0 cnt=%0d/1 blank=%0d/3",
               np, move_count, blank_idx);
    end
  endtask

  task automatic test_undo();
    int lat;
    brd_t s = '{1, 2, 3, 4, 5, 6, 7, 0, 8};
    do_load(s, lat);
    drive(5'b00010);
    step();
    drive(5'b00000);
    step();
    checks++;
    if (solved !== 1'b1 || blank_idx !== 4'd8 || move_count !== 10'd1) begin
      failures++;
      $display("FAIL undo_pre sol=%b/1 blank=%0d/8 cnt=%0d/1", solved, blank_idx, move_count);
    end
    drive(5'b10000);
    step();
`ifdef PUZZLE_UNDO_EN
    checks++;
    if (board_out !== pk(s) || blank_idx !== 4'd7 || move_count !== 10'd1 ||
        move_pulse !== 1'b1 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL undo_apply board=%h/%h blank=%0d/7 cnt=%0d/1 pulse=%b/1",
               board_out, pk(s), blank_idx, move_count, move_pulse);
    end
    drive(5'b00000);
    step();
    drive(5'b10000);
    step();
    checks++;
    if (illegal !== 1'b1 || move_pulse !== 1'b0 || blank_idx !== 4'd7) begin
      failures++;
      $display("FAIL undo_empty ill=%b/1 pulse=%b/0 blank=%0d/7", illegal, move_pulse, blank_idx);
    end
`else
    checks++;
    if (blank_idx !== 4'd8 || move_pulse !== 1'b0 || illegal !== 1'b0 ||
        move_count !== 10'd1) begin
      failures++;
      $display("FAIL undo_ignored blank=%0d/8 pulse=%b/0 ill=%b/0 cnt=%0d/1",
               blank_idx, move_pulse, illegal, move_count);
    end
`endif
    drive(5'b00000);
    step();
  endtask

  task automatic test_no_blank_idle();
    int lat;
    int np;
    brd_t s = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    do_load(s, lat);
    checks++;
    if (lat != 9 || no_blank !== 1'b1 || ready !== 1'b0 || board_out !== pk(s)) begin
      failures++;
      $display("FAIL no_blank lat=%0d/9 nob=%b/1 rdy=%b/0", lat, no_blank, ready);
    end
    np = 0;
    drive(5'b00010);
    step();
    np += int'(move_pulse) + int'(illegal);
    drive(5'b00000);
    step();
    np += int'(move_pulse) + int'(illegal);
    checks++;
    if (np != 0 || board_out !== pk(s) || no_blank !== 1'b1) begin
      failures++;
      $display("FAIL idle_ignore pulses=%0d/0 nob=%b/1", np, no_blank);
    end
  endtask

  task automatic test_scan_ignore_and_reset();
    int np;
    brd_t s = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
    board_in = pk(s);
    load = 1'b1;
    step();
    load = 1'b0;
    np = 0;
    for (int i = 0; i < 4; i++) begin
      drive((i % 2 == 0) ? 5'b00011 : 5'b00000);
      step();
      np += int'(move_pulse) + int'(illegal);
    end
    checks++;
    if (np != 0 || ready !== 1'b0 || board_out !== pk(s)) begin
      failures++;
      $display("FAIL scan_ignore pulses=%0d/0 rdy=%b/0", np, ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (board_out !== '0 || ready !== 1'b0 || blank_idx !== '0 || move_count !== '0) begin
      failures++;
      $display("FAIL reset_mid_scan board=%h/0 rdy=%b/0 blank=%0d/0", board_out, ready, blank_idx);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (ready !== 1'b0 || board_out !== '0 || no_blank !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard rdy=%b/0 board=%h/0 nob=%b/0", ready, board_out, no_blank);
    end
  endtask

  task automatic test_saturation();
    int lat;
    brd_t s = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
    do_load(s, lat);
    for (int i = 0; i < 1030; i++) begin
      drive((i % 2 == 0) ? 5'b00001 : 5'b00010);
      step();
      drive(5'b00000);
      step();
    end
    checks++;
    if (move_count !== 10'(CMAX) || solved !== 1'b1 || blank_idx !== 4'd8) begin
      failures++;
      $display("FAIL count_saturate cnt=%0d/%0d sol=%b/1 blank=%0d/8",
               move_count, CMAX, solved, blank_idx);
    end
  endtask

  task automatic test_random();
    brd_t p;
    int lat, j, t;
    logic [4:0] m;
    bit ep, ei;
    for (int rd = 0; rd < 6; rd++) begin
      for (int k = 0; k < N; k++) p[k] = k;
      for (int k = N - 1; k > 0; k--) begin
        j = $urandom_range(k, 0);
        t = p[k];
        p[k] = p[j];
        p[j] = t;
      end
      do_load(p, lat);
      checks++;
      if (lat != mbl + 1 || blank_idx !== IW'(mbl)) begin
        failures++;
        $display("FAIL rand_load lat=%0d/%0d blank=%0d/%0d", lat, mbl + 1, blank_idx, mbl);
      end
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(1, 0) == 1) m = 5'(1 << $urandom_range(4, 0));
        else m = 5'($urandom_range(31, 1));
        drive(m);
        step();
        model_press(m, ep, ei);
        checks++;
        if (board_out !== pk(mb) || blank_idx !== IW'(mbl) ||
            move_count !== CNTW'(mcnt) || move_pulse !== ep ||
            illegal !== ei || solved !== msolved()) begin
          failures++;
          $display("FAIL rand_move m=%b board=%h/%h blank=%0d/%0d cnt=%0d/%0d pulse=%b/%b ill=%b/%b sol=%b/%b",
                   m, board_out, pk(mb), blank_idx, mbl, move_count, mcnt,
                   move_pulse, ep, illegal, ei, solved, msolved());
        end
        drive(5'b00000);
        step();
        checks++;
        if (move_pulse !== 1'b0 || illegal !== 1'b0) begin
          failures++;
          $display("FAIL rand_release pulse=%b/0 ill=%b/0", move_pulse, illegal);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_solved_and_left();
    test_edges();
    test_priority_hold();
    test_undo();
    test_no_blank_idle();
    test_scan_ignore_and_reset();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
